weight_loader: RTL

// Write master for the network's parameter-RAM write port ({w_en, w_data, w_addr}); it is the producer side of that port.

---
 rtl/weight_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
//
// Write master for the network's parameter-RAM write port. A flat stream of
// parameter words arrives over valid/ready after a start_i pulse; each accepted
// word becomes exactly one RAM write one cycle later. Writes walk
// layer -> RAM select -> in-RAM address, packed as {layer, ram_sel, ram_addr}.
//
// Handshake: a word transfers on any rising clk_i edge where valid_i and
// ready_o are both high. ready_o depends on the FSM state only, never on
// valid_i. The producer may hold valid_i for any number of cycles. A word that
// is offered while ready_o is low is not consumed.
//
// Ports
//   clk_i      in   clock
//   reset_n_i  in   asynchronous active-low reset
//   start_i    in   1-cycle pulse that begins a load (ignored while loading)
//   data_i     in   parameter word
//   valid_i    in   data_i valid
//   ready_o    out  loader accepts data_i this cycle (high in LOAD)
//   w_en_o     out  RAM write strobe (registered)
//   w_data_o   out  RAM write data (registered, holds between writes)
//   w_addr_o   out  packed {layer, ram_sel, ram_addr} (registered, holds)
//   busy_o     out  high while loading
//   done_o     out  high after the final word until the next start_i
//   state_o    out  debug view of the FSM state
// -----------------------------------------------------------------------------
module weight_loader #(
    parameter int MEM_WORD_SIZE     = 21,
    parameter int LAYER_SELECT_BITS = 2,
    parameter int RAM_SELECT_BITS   = 8,
    parameter int RAM_ADDRESS_BITS  = 9,
    parameter int L0_RAMS           = 256,
    parameter int L0_DEPTH          = 33,
    parameter int L1_RAMS           = 256,
    parameter int L1_DEPTH          = 257,
    parameter int L2_RAMS           = 4,
    parameter int L2_DEPTH          = 256,
    parameter int L3_RAMS           = 10,
    parameter int L3_DEPTH          = 257
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         start_i,
    input  logic [MEM_WORD_SIZE-1:0]     data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         w_en_o,
    output logic [MEM_WORD_SIZE-1:0]     w_data_o,
    output logic [LAYER_SELECT_BITS+RAM_SELECT_BITS+RAM_ADDRESS_BITS-1:0] w_addr_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [1:0]                   state_o
);

    // Elaboration-time sanity checks on the geometry.
    if (LAYER_SELECT_BITS < 2) begin : g_chk_layer
        $error("weight_loader: LAYER_SELECT_BITS must hold layer index 3");
    end
    if (L0_RAMS > 2**RAM_SELECT_BITS || L1_RAMS > 2**RAM_SELECT_BITS ||
        L2_RAMS > 2**RAM_SELECT_BITS || L3_RAMS > 2**RAM_SELECT_BITS) begin : g_chk_rams
        $error("weight_loader: a layer RAM count exceeds the RAM select field");
    end
    if (L0_DEPTH > 2**RAM_ADDRESS_BITS || L1_DEPTH > 2**RAM_ADDRESS_BITS ||
        L2_DEPTH > 2**RAM_ADDRESS_BITS || L3_DEPTH > 2**RAM_ADDRESS_BITS) begin : g_chk_depth
        $error("weight_loader: a layer depth exceeds the RAM address field");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [LAYER_SELECT_BITS-1:0] layer_q;
    logic [RAM_SELECT_BITS-1:0]   ram_q;
    logic [RAM_ADDRESS_BITS-1:0]  addr_q;

    int   cur_rams;
    int   cur_depth;
    logic accept;
    logic addr_last;
    logic ram_last;
    logic last_word;
    logic clr_cnt;

    // Geometry of the layer currently being written.
    always_comb begin
        cur_rams  = L3_RAMS;
        cur_depth = L3_DEPTH;
        case (32'(layer_q))
            0:       begin cur_rams = L0_RAMS; cur_depth = L0_DEPTH; end
            1:       begin cur_rams = L1_RAMS; cur_depth = L1_DEPTH; end
            2:       begin cur_rams = L2_RAMS; cur_depth = L2_DEPTH; end
            default: ;
        endcase
    end

    assign accept    = valid_i & ready_o;
    assign addr_last = (32'(addr_q) == 32'(cur_depth - 1));
    assign ram_last  = (32'(ram_q) == 32'(cur_rams - 1));
    assign last_word = (32'(layer_q) == 32'd3) & ram_last & addr_last;

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; clr_cnt restarts the walk at layer 0 on every start.
    always_comb begin
        state_d = state_q;
        clr_cnt = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_LOAD;
                    clr_cnt = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept && last_word) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ready_o = (state_q == ST_LOAD);
    assign busy_o  = (state_q == ST_LOAD);
    assign done_o  = (state_q == ST_DONE);
    assign state_o = state_q;

    // Address walk: addr fastest, then RAM select, then layer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            layer_q <= '0;
            ram_q   <= '0;
            addr_q  <= '0;
        end else if (clr_cnt) begin
            layer_q <= '0;
            ram_q   <= '0;
            addr_q  <= '0;
        end else if (accept) begin
            if (addr_last) begin
                addr_q <= '0;
                if (ram_last) begin
                    ram_q   <= '0;
                    layer_q <= layer_q + LAYER_SELECT_BITS'(1);
                end else begin
                    ram_q <= ram_q + RAM_SELECT_BITS'(1);
                end
            end else begin
                addr_q <= addr_q + RAM_ADDRESS_BITS'(1);
            end
        end
    end

    // Registered write port; data/address hold their last value between writes.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_en_o   <= 1'b0;
            w_data_o <= '0;
            w_addr_o <= '0;
        end else begin
            w_en_o <= accept;
            if (accept) begin
                w_data_o <= data_i;
                w_addr_o <= {layer_q, ram_q, addr_q};
            end
        end
    end

endmodule
